// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings used by the branch resolution logic, plus the
// 2-bit saturating counter step used by the direction table.
package rv32i_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Weakly not taken.
    localparam logic [1:0] BHT_INIT = 2'b01;

    function automatic logic [1:0] bht_sat_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Direction table of 2-bit saturating counters: one combinational read port
// for Fetch, one synchronous update port from Execute, synchronous reset to 01.
module branch_bht
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr_q [DEPTH];

    // No bypass: a same-cycle update is only visible after the edge.
    assign rd_taken = ctr_q[rd_idx][1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctr_q[i] <= BHT_INIT;
            end
        end else if (upd_en) begin
            ctr_q[upd_idx] <= bht_sat_next(ctr_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: outcome, target, mispredict redirect and
// direction-table training. Optional perf counters under BRU_PERF_CNT_EN.
module branch_resolve_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned PC_LSB    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            kill,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            resolve_taken,
    output logic [XLEN-1:0] link_pc,
    output logic            misalign_fault,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic            is_branch, is_jal, is_jalr, active;
    logic            eq, lt_s, lt_u, cond_taken, taken;
    logic [XLEN-1:0] pc_plus4, target, next_pc;
    logic            mispredict, misaligned, redirect_d, fault_d;

    logic            redirect_valid_q, resolve_taken_q, misalign_fault_q;
    logic [XLEN-1:0] redirect_pc_q, link_pc_q;

    assign is_branch = (ex_opcode == OPC_BRANCH);
    assign is_jal    = (ex_opcode == OPC_JAL);
    assign is_jalr   = (ex_opcode == OPC_JALR);
    assign active    = ex_valid && !kill && (is_branch || is_jal || is_jalr);

    assign eq   = (ex_rs1 == ex_rs2);
    assign lt_s = ($signed(ex_rs1) < $signed(ex_rs2));
    assign lt_u = (ex_rs1 < ex_rs2);

    always_comb begin
        cond_taken = 1'b0;
        case (ex_funct3)
            F3_BEQ:  cond_taken = eq;
            F3_BNE:  cond_taken = !eq;
            F3_BLT:  cond_taken = lt_s;
            F3_BGE:  cond_taken = !lt_s;
            F3_BLTU: cond_taken = lt_u;
            F3_BGEU: cond_taken = !lt_u;
            default: cond_taken = 1'b0;
        endcase
    end

    assign taken    = is_jal || is_jalr || (is_branch && cond_taken);
    assign pc_plus4 = ex_pc + XLEN'(4);
    assign target   = is_jalr ? ((ex_rs1 + ex_imm) & ~XLEN'(1)) : (ex_pc + ex_imm);
    assign next_pc  = taken ? target : pc_plus4;

    assign mispredict = (taken != ex_pred_taken) || (taken && (target != ex_pred_target));
    // A misaligned taken target faults instead of redirecting.
    assign misaligned = taken && target[1];
    assign redirect_d = active && mispredict && !misaligned;
    assign fault_d    = active && misaligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            misalign_fault_q <= 1'b0;
            resolve_taken_q  <= 1'b0;
            redirect_pc_q    <= '0;
            link_pc_q        <= '0;
        end else begin
            redirect_valid_q <= redirect_d;
            misalign_fault_q <= fault_d;
            if (active) begin
                resolve_taken_q <= taken;
                redirect_pc_q   <= next_pc;
                if (is_jal || is_jalr) begin
                    link_pc_q <= pc_plus4;
                end
            end
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign misalign_fault = misalign_fault_q;
    assign resolve_taken  = resolve_taken_q;
    assign redirect_pc    = redirect_pc_q;
    assign link_pc        = link_pc_q;

    // Only the index bits of the Fetch PC reach the table.
    logic unused_if_pc;
    assign unused_if_pc = ^if_pc;

    branch_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[PC_LSB +: IDX_W]),
        .rd_taken  (if_pred_taken),
        .upd_en    (active && is_branch),
        .upd_idx   (ex_pc[PC_LSB +: IDX_W]),
        .upd_taken (cond_taken)
    );

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_mispredicts_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            if (active) begin
                perf_branches_q <= perf_branches_q + 32'd1;
            end
            if (redirect_d) begin
                perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table through a
// scoreboard queue, then counter saturation/collision and reset sequences.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, kill, ex_pred_taken;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_target, if_pc;
    logic        if_pred_taken, redirect_valid, resolve_taken, misalign_fault;
    logic [31:0] redirect_pc, link_pc, perf_branches, perf_mispredicts;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN      (32),
        .BHT_DEPTH (64),
        .PC_LSB    (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_opcode        (ex_opcode),
        .ex_funct3        (ex_funct3),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .kill             (kill),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .resolve_taken    (resolve_taken),
        .link_pc          (link_pc),
        .misalign_fault   (misalign_fault),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic        kl;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] pc, imm, rs1, rs2;
        logic        pt;
        logic [31:0] ptgt, ifpc;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_rt;
        logic [31:0] e_link;
        logic        e_mis;
        logic        e_ifp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_br  = 0;
    int   m_mp  = 0;

    function automatic vec_t mk(string name, logic valid, logic kl, logic [6:0] opc,
                                logic [2:0] f3, logic [31:0] pc, logic [31:0] imm,
                                logic [31:0] rs1, logic [31:0] rs2, logic pt,
                                logic [31:0] ptgt, logic [31:0] ifpc, logic e_rv,
                                logic [31:0] e_rpc, logic e_rt, logic [31:0] e_link,
                                logic e_mis, logic e_ifp);
        vec_t v;
        v.name = name; v.valid = valid; v.kl = kl; v.opc = opc; v.f3 = f3;
        v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.pt = pt; v.ptgt = ptgt;
        v.ifpc = ifpc; v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_rt = e_rt; v.e_link = e_link;
        v.e_mis = e_mis; v.e_ifp = e_ifp;
        return v;
    endfunction

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_valid = v.valid; kill = v.kl; ex_opcode = v.opc; ex_funct3 = v.f3;
        ex_pc = v.pc; ex_imm = v.imm; ex_rs1 = v.rs1; ex_rs2 = v.rs2;
        ex_pred_taken = v.pt; ex_pred_target = v.ptgt; if_pc = v.ifpc;
    endtask

    task automatic idle();
        ex_valid = 1'b0; kill = 1'b0; ex_opcode = 7'h13; ex_funct3 = 3'd0;
        ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_rs2 = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
    endtask

    task automatic check_perf(input string tag, input int br, input int mp);
`ifdef BRU_PERF_CNT_EN
        check({tag, ".perf_br"}, perf_branches, 32'(br));
        check({tag, ".perf_mp"}, perf_mispredicts, 32'(mp));
`else
        check({tag, ".perf_br"}, perf_branches, 32'd0);
        check({tag, ".perf_mp"}, perf_mispredicts, 32'd0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v, e;
        logic [1:0] ctr;
        logic [6:0] op;
        rst_n = 1'b1;
        if_pc = 32'h100;
        idle();

        //          name     vld k opc    f3  pc       imm          rs1          rs2          pt ptgt         ifpc      rv rpc          rt link     mis ifp
        vecs.push_back(mk("beq",   1, 0, 7'h63, 0, 32'h100, 32'h20,       32'd5,       32'd5,       0, 32'h104,  32'h100, 1, 32'h120, 1, 32'h0,   0, 1));
        vecs.push_back(mk("blt",   1, 0, 7'h63, 4, 32'h104, 32'h40,       32'hFFFFFFFF, 32'd1,      1, 32'h144,  32'h104, 0, 32'h0,   1, 32'h0,   0, 1));
        vecs.push_back(mk("bltu",  1, 0, 7'h63, 6, 32'h108, 32'h40,       32'hFFFFFFFF, 32'd1,      1, 32'h148,  32'h108, 1, 32'h10C, 0, 32'h0,   0, 0));
        vecs.push_back(mk("jalr",  1, 0, 7'h67, 0, 32'h200, 32'h0,        32'h1001,    32'd0,       1, 32'h1000, 32'h100, 0, 32'h0,   1, 32'h204, 0, 1));
        vecs.push_back(mk("jalrma",1, 0, 7'h67, 0, 32'h200, 32'h0,        32'h1002,    32'd0,       1, 32'h1002, 32'h100, 0, 32'h0,   1, 32'h204, 1, 1));
        vecs.push_back(mk("jal",   1, 0, 7'h6F, 0, 32'h300, 32'hFFFFFFF0, 32'd0,       32'd0,       0, 32'h304,  32'h100, 1, 32'h2F0, 1, 32'h304, 0, 1));
        vecs.push_back(mk("bne",   1, 0, 7'h63, 1, 32'h10C, 32'h8,        32'd3,       32'd3,       0, 32'h110,  32'h10C, 0, 32'h0,   0, 32'h304, 0, 0));
        vecs.push_back(mk("bgetgt",1, 0, 7'h63, 5, 32'h110, 32'h8,        32'd1,       32'hFFFFFFFF, 1, 32'h200, 32'h110, 1, 32'h118, 1, 32'h304, 0, 1));
        vecs.push_back(mk("bgeu",  1, 0, 7'h63, 7, 32'h114, 32'h8,        32'd1,       32'hFFFFFFFF, 0, 32'h118, 32'h114, 0, 32'h0,   0, 32'h304, 0, 0));
        vecs.push_back(mk("f3_010",1, 0, 7'h63, 2, 32'h118, 32'h8,        32'd0,       32'd0,       1, 32'h200,  32'h118, 1, 32'h11C, 0, 32'h304, 0, 0));
        vecs.push_back(mk("nonctl",1, 0, 7'h33, 0, 32'h11C, 32'h8,        32'd0,       32'd0,       1, 32'h200,  32'h11C, 0, 32'h0,   0, 32'h304, 0, 0));
        vecs.push_back(mk("bmis",  1, 0, 7'h63, 0, 32'h120, 32'h6,        32'd7,       32'd7,       1, 32'h126,  32'h120, 0, 32'h0,   1, 32'h304, 1, 1));
        vecs.push_back(mk("inval", 0, 0, 7'h63, 0, 32'h124, 32'h20,       32'd1,       32'd1,       0, 32'h128,  32'h124, 0, 32'h0,   1, 32'h304, 0, 0));
        vecs.push_back(mk("killed",1, 1, 7'h63, 1, 32'h124, 32'h20,       32'd1,       32'd2,       0, 32'h128,  32'h124, 0, 32'h0,   1, 32'h304, 0, 0));
        vecs.push_back(mk("b2b_a", 1, 0, 7'h63, 0, 32'h140, 32'h10,       32'd0,       32'd0,       0, 32'h144,  32'h140, 1, 32'h150, 1, 32'h304, 0, 1));
        vecs.push_back(mk("b2b_b", 1, 0, 7'h63, 1, 32'h144, 32'hFFFFFF00, 32'd1,       32'd0,       0, 32'h148,  32'h144, 1, 32'h44,  1, 32'h304, 0, 1));

        // Reset state
        do_reset();
        if_pc = 32'h100;
        #1;
        check("rst.rv", 32'(redirect_valid), 32'd0);
        check("rst.rpc", redirect_pc, 32'd0);
        check("rst.rt", 32'(resolve_taken), 32'd0);
        check("rst.link", link_pc, 32'd0);
        check("rst.mis", 32'(misalign_fault), 32'd0);
        check("rst.ifp", 32'(if_pred_taken), 32'd0);
        check_perf("rst", 0, 0);

        // Table vectors through the scoreboard; back-to-back, one per cycle
        foreach (vecs[i]) begin
            @(negedge clk);
            v = vecs[i];
            drive(v);
            sb.push_back(v);
            op = v.opc;
            if (v.valid && !v.kl && (op == 7'h63 || op == 7'h6F || op == 7'h67)) m_br++;
            if (v.e_rv) m_mp++;
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL %s: scoreboard empty", v.name);
            end else begin
                e = sb.pop_front();
                check({e.name, ".rv"}, 32'(redirect_valid), 32'(e.e_rv));
                if (e.e_rv) check({e.name, ".rpc"}, redirect_pc, e.e_rpc);
                check({e.name, ".rt"}, 32'(resolve_taken), 32'(e.e_rt));
                check({e.name, ".link"}, link_pc, e.e_link);
                check({e.name, ".mis"}, 32'(misalign_fault), 32'(e.e_mis));
                check({e.name, ".ifp"}, 32'(if_pred_taken), 32'(e.e_ifp));
                check_perf(e.name, m_br, m_mp);
            end
        end

        // Saturation and same-cycle read/update collision at idx 32
        do_reset();
        ctr = 2'b01;
        for (int k = 0; k < 6; k++) begin
            logic tk;
            tk = (k < 4);
            @(negedge clk);
            drive(mk("sat", 1, 0, 7'h63, 0, 32'h180, 32'h10, 32'(tk ? 0 : 1), 32'd0,
                     tk, tk ? 32'h190 : 32'h184, 32'h180, 0, 0, 0, 0, 0, 0));
            #1;
            check($sformatf("sat%0d.pre_ifp", k), 32'(if_pred_taken), 32'(ctr[1]));
            @(posedge clk);
            if (tk) ctr = (ctr == 2'b11) ? ctr : ctr + 2'd1;
            else    ctr = (ctr == 2'b00) ? ctr : ctr - 2'd1;
            #1;
            check($sformatf("sat%0d.post_ifp", k), 32'(if_pred_taken), 32'(ctr[1]));
            check($sformatf("sat%0d.rv", k), 32'(redirect_valid), 32'd0);
        end
        // Train idx 32 to strongly taken before reset
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(mk("tr", 1, 0, 7'h63, 0, 32'h180, 32'h10, 32'd0, 32'd0, 1, 32'h190,
                     32'h180, 0, 0, 0, 0, 0, 0));
        end

        // Mid-operation reset with a mispredicting JAL in flight
        @(negedge clk);
        drive(mk("rstjal", 1, 0, 7'h6F, 0, 32'h100, 32'h20, 32'd0, 32'd0, 0, 32'h104,
                 32'h180, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst.rv", 32'(redirect_valid), 32'd0);
        check("midrst.rpc", redirect_pc, 32'd0);
        check("midrst.rt", 32'(resolve_taken), 32'd0);
        check("midrst.link", link_pc, 32'd0);
        check_perf("midrst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            check($sformatf("midrst.ifp[%0d]", i), 32'(if_pred_taken), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
